// File: rtl/grid_load_pkg.sv
// Shared types and constants for the grid character loader.
// Pure declarations: no logic, no latency, no flow control.
package grid_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    localparam int ERR_RAGGED  = 2;
    localparam int ERR_ROW_OVF = 1;
    localparam int ERR_COL_OVF = 0;

    // Fields are sized for the largest supported geometry; narrower instances zero-extend.
    localparam int PKT_ROW_W  = 16;
    localparam int PKT_COL_W  = 16;
    localparam int PKT_DATA_W = 64;

    typedef struct packed {
        logic [PKT_ROW_W-1:0]  row;
        logic [PKT_COL_W-1:0]  col;
        logic [PKT_DATA_W-1:0] data;
    } wr_packet_t;

endpackage

// File: rtl/grid_char_packer_if.sv
// Byte-stream, grid-memory write and status signals of the grid loader.
// Wiring only; master is the packer, slave is the host/memory side.
interface grid_char_packer_if #(
    parameter int DATA_W     = 16,
    parameter int ROW_ADDR_W = 8,
    parameter int COL_ADDR_W = 8
);
    logic                  start_in;
    logic                  char_valid_in;
    logic [7:0]            char_in;
    logic                  char_last_in;
    logic                  char_ready_out;
    logic                  wr_req_out;
    logic [ROW_ADDR_W-1:0] wr_row_out;
    logic [COL_ADDR_W-1:0] wr_col_out;
    logic [DATA_W-1:0]     wr_data_out;
    logic                  mem_ack_in;
    logic                  done_out;
    logic [ROW_ADDR_W:0]   rows_out;
    logic [COL_ADDR_W:0]   cols_out;
    logic [2:0]            err_out;

    modport master (
        input  start_in, char_valid_in, char_in, char_last_in, mem_ack_in,
        output char_ready_out, wr_req_out, wr_row_out, wr_col_out, wr_data_out,
        output done_out, rows_out, cols_out, err_out
    );

    modport slave (
        output start_in, char_valid_in, char_in, char_last_in, mem_ack_in,
        input  char_ready_out, wr_req_out, wr_row_out, wr_col_out, wr_data_out,
        input  done_out, rows_out, cols_out, err_out
    );

endinterface

// File: rtl/grid_char_packer_chunk_accum.sv
// Chunk register: sets one bit per cell at the given index; full flags the last index.
// Bit written one cycle after set_en; clear wins over set; no backpressure.
module chunk_accum #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              set_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic              val,
    output logic [DATA_W-1:0] data,
    output logic              full
);

    assign full = set_en && (idx == IDX_W'(DATA_W - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            data <= '0;
        end else if (set_en) begin
            data[idx] <= val;
        end
    end

endmodule

// File: rtl/grid_char_packer.sv
// Packs a text-grid byte stream into DATA_W-bit match chunks and writes them row/column addressed.
// One byte per cycle while loading; stream stalls (ready low) while a write waits for mem_ack_in.
module grid_char_packer
    import grid_load_pkg::*;
#(
    parameter int         DATA_W     = 16,
    parameter int         MAX_COLS   = 144,
    parameter int         ROW_ADDR_W = 8,
    parameter int         COL_ADDR_W = $clog2(MAX_COLS),
    parameter logic [7:0] MATCH_CHAR = 8'h40
) (
    input logic                clock,
    input logic                reset,
    grid_char_packer_if.master bus
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int CW    = COL_ADDR_W + 1;
    localparam int RW    = ROW_ADDR_W + 1;
    localparam logic [CW-1:0] COL_LIMIT = CW'(MAX_COLS);
    localparam logic [RW-1:0] ROW_LIMIT = RW'(2 ** ROW_ADDR_W);

    state_t                state, state_nxt;
    logic [CW-1:0]         col_cnt, col_after, cols_lat;
    logic [RW-1:0]         row_cnt;
    logic [IDX_W-1:0]      bit_idx, idx_after;
    logic [COL_ADDR_W-1:0] chunk_col, wr_col;
    logic [ROW_ADDR_W-1:0] wr_row;
    logic [DATA_W-1:0]     acc_data;
    logic [2:0]            err;
    logic                  first_seen, row_pend, end_pend;
    logic                  start_ok, accept, is_lf, is_cr, is_data, take, col_ovf_hit;
    logic                  acc_full, acc_clear, last, row_end, flush, issue, suppress;
    logic                  ack, row_close;

    assign start_ok    = bus.start_in && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept      = (state == ST_LOAD) && bus.char_valid_in;
    assign is_lf       = (bus.char_in == CHAR_LF);
    assign is_cr       = (bus.char_in == CHAR_CR);
    assign is_data     = !is_lf && !is_cr;
    assign take        = accept && is_data && (col_cnt != COL_LIMIT);
    assign col_ovf_hit = accept && is_data && (col_cnt == COL_LIMIT);
    assign col_after   = take ? col_cnt + CW'(1) : col_cnt;
    assign idx_after   = acc_full ? '0 : (take ? bit_idx + IDX_W'(1) : bit_idx);
    assign last        = accept && bus.char_last_in;
    assign row_end     = accept && ((is_lf && (col_cnt != '0)) ||
                                    (bus.char_last_in && (col_after != '0)));
    // A full chunk always goes out; a partial one only when its row ends.
    assign flush       = acc_full || (row_end && (idx_after != '0));
    assign issue       = flush && (row_cnt != ROW_LIMIT);
    assign suppress    = flush && (row_cnt == ROW_LIMIT);
    assign ack         = (state == ST_WRITE) && bus.mem_ack_in;
    assign row_close   = (row_end && !issue) || (ack && row_pend);
    assign acc_clear   = start_ok || ack || suppress;

    chunk_accum #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .set_en (take),
        .idx    (bit_idx),
        .val    (bus.char_in == MATCH_CHAR),
        .data   (acc_data),
        .full   (acc_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.char_ready_out = 1'b0;
        bus.wr_req_out     = 1'b0;
        bus.done_out       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                bus.char_ready_out = 1'b1;
                if (issue) begin
                    state_nxt = ST_WRITE;
                end else if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                bus.wr_req_out = 1'b1;
                if (bus.mem_ack_in) state_nxt = end_pend ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                bus.done_out = 1'b1;
                if (start_ok) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            col_cnt    <= '0;
            cols_lat   <= '0;
            row_cnt    <= '0;
            bit_idx    <= '0;
            chunk_col  <= '0;
            wr_col     <= '0;
            wr_row     <= '0;
            err        <= '0;
            first_seen <= 1'b0;
            row_pend   <= 1'b0;
            end_pend   <= 1'b0;
        end else begin
            if (accept) begin
                col_cnt <= col_after;
                bit_idx <= idx_after;
                if (acc_full) chunk_col <= chunk_col + COL_ADDR_W'(DATA_W);
                if (issue) begin
                    wr_row   <= row_cnt[ROW_ADDR_W-1:0];
                    wr_col   <= chunk_col;
                    row_pend <= row_end;
                    end_pend <= last;
                end
                if (col_ovf_hit) err[ERR_COL_OVF] <= 1'b1;
                if (suppress) err[ERR_ROW_OVF] <= 1'b1;
                // The first completed row defines the grid width.
                if (row_end) begin
                    if (!first_seen) begin
                        cols_lat   <= col_after;
                        first_seen <= 1'b1;
                    end else if (col_after != cols_lat) begin
                        err[ERR_RAGGED] <= 1'b1;
                    end
                end
            end
            if (ack) row_pend <= 1'b0;
            if (row_close) begin
                if (row_cnt != ROW_LIMIT) row_cnt <= row_cnt + RW'(1);
                col_cnt   <= '0;
                bit_idx   <= '0;
                chunk_col <= '0;
            end
        end
    end

    assign bus.wr_row_out  = (state == ST_WRITE) ? wr_row : '0;
    assign bus.wr_col_out  = (state == ST_WRITE) ? wr_col : '0;
    assign bus.wr_data_out = (state == ST_WRITE) ? acc_data : '0;
    assign bus.rows_out    = row_cnt;
    assign bus.cols_out    = cols_lat;
    assign bus.err_out     = err;

endmodule

// File: tb/tb_grid_char_packer.sv
// Directed bench for grid_char_packer with DATA_W=4, MAX_COLS=10, ROW_ADDR_W=2.
// A negedge memory model records writes and checks request stability while ack is held off.
module tb_grid_char_packer;
    import grid_load_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_ack = 1'b0;

    always #5 clk = ~clk;

    grid_char_packer_if #(.DATA_W(4), .ROW_ADDR_W(2), .COL_ADDR_W(4)) bus ();

    grid_char_packer #(
        .DATA_W     (4),
        .MAX_COLS   (10),
        .ROW_ADDR_W (2),
        .COL_ADDR_W (4),
        .MATCH_CHAR (8'h40)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    assign bus.mem_ack_in = mem_ack;

    int         checks = 0;
    int         errors = 0;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         hold_cnt = 0;
    wr_packet_t got_q[$];
    wr_packet_t cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after ack_delay held cycles, sampling on the falling edge.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (bus.wr_req_out) begin
            if (wait_cnt == 0) begin
                cur.row  = 16'(bus.wr_row_out);
                cur.col  = 16'(bus.wr_col_out);
                cur.data = 64'(bus.wr_data_out);
                got_q.push_back(cur);
            end else begin
                hold_cnt++;
                chk("hold_row", 64'(bus.wr_row_out), 64'(cur.row));
                chk("hold_col", 64'(bus.wr_col_out), 64'(cur.col));
                chk("hold_data", 64'(bus.wr_data_out), cur.data);
                chk("hold_ready", 64'(bus.char_ready_out), 64'(0));
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic pulse_start();
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int n = 0;
        bus.char_valid_in = 1'b1;
        bus.char_in       = b;
        bus.char_last_in  = l;
        while (!bus.char_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(n < 100), 64'(1));
        @(negedge clk);
        bus.char_valid_in = 1'b0;
        bus.char_last_in  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic l);
        for (int i = 0; i < s.len(); i++) send(s[i], l && (i == s.len() - 1));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(bus.done_out), 64'(1));
    endtask

    task automatic chk_wr(input string tag, input int idx, input int row, input int col,
                          input logic [63:0] data);
        wr_packet_t g;
        if (idx < got_q.size()) g = got_q[idx];
        else g = '1;
        chk({tag, "_row"}, 64'(g.row), 64'(row));
        chk({tag, "_col"}, 64'(g.col), 64'(col));
        chk({tag, "_data"}, g.data, data);
    endtask

    initial begin
        int base;
        int h0;
        rst               = 1'b1;
        bus.start_in      = 1'b0;
        bus.char_valid_in = 1'b0;
        bus.char_in       = 8'h00;
        bus.char_last_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.char_ready_out), 64'(0));
        chk("rst_req", 64'(bus.wr_req_out), 64'(0));
        chk("rst_done", 64'(bus.done_out), 64'(0));
        chk("rst_rows", 64'(bus.rows_out), 64'(0));
        chk("rst_cols", 64'(bus.cols_out), 64'(0));
        chk("rst_err", 64'(bus.err_out), 64'(0));
        chk("rst_data", 64'(bus.wr_data_out), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Two chunks in one row, partial flush on the final newline.
        base = got_q.size();
        pulse_start();
        send_str("@@.@@\n", 1'b1);
        wait_done("t1_done");
        chk_wr("t1_w0", base, 0, 0, 64'b1011);
        chk_wr("t1_w1", base + 1, 0, 4, 64'b0001);
        chk("t1_nwr", 64'(got_q.size() - base), 64'(2));
        chk("t1_rows", 64'(bus.rows_out), 64'(1));
        chk("t1_cols", 64'(bus.cols_out), 64'(5));
        chk("t1_err", 64'(bus.err_out), 64'(0));
        repeat (3) @(negedge clk);
        chk("t1_done_hold", 64'(bus.done_out), 64'(1));

        // CR and blank line ignored.
        base = got_q.size();
        pulse_start();
        chk("t2_done_clr", 64'(bus.done_out), 64'(0));
        send_str("@@@@\015\n\n.@..\n", 1'b1);
        wait_done("t2_done");
        chk_wr("t2_w0", base, 0, 0, 64'b1111);
        chk_wr("t2_w1", base + 1, 1, 0, 64'b0010);
        chk("t2_nwr", 64'(got_q.size() - base), 64'(2));
        chk("t2_rows", 64'(bus.rows_out), 64'(2));
        chk("t2_cols", 64'(bus.cols_out), 64'(4));
        chk("t2_err", 64'(bus.err_out), 64'(0));

        // Ack held off five cycles per write.
        ack_delay = 5;
        h0 = hold_cnt;
        base = got_q.size();
        pulse_start();
        send_str("@@.@@\n", 1'b1);
        wait_done("t3_done");
        chk_wr("t3_w0", base, 0, 0, 64'b1011);
        chk_wr("t3_w1", base + 1, 0, 4, 64'b0001);
        chk("t3_hold", 64'(hold_cnt - h0), 64'(10));
        chk("t3_rows", 64'(bus.rows_out), 64'(1));
        ack_delay = 0;

        // Ragged second row.
        base = got_q.size();
        pulse_start();
        send_str("@@@\n@@\n", 1'b1);
        wait_done("t4_done");
        chk_wr("t4_w0", base, 0, 0, 64'b0111);
        chk_wr("t4_w1", base + 1, 1, 0, 64'b0011);
        chk("t4_err", 64'(bus.err_out), 64'b100);
        chk("t4_cols", 64'(bus.cols_out), 64'(3));
        chk("t4_rows", 64'(bus.rows_out), 64'(2));

        // Five rows into a four-row memory.
        base = got_q.size();
        pulse_start();
        send_str("@\n@\n@\n@\n@\n", 1'b1);
        wait_done("t5_done");
        chk("t5_nwr", 64'(got_q.size() - base), 64'(4));
        chk_wr("t5_w0", base, 0, 0, 64'b0001);
        chk_wr("t5_w3", base + 3, 3, 0, 64'b0001);
        chk("t5_err", 64'(bus.err_out), 64'b010);
        chk("t5_rows", 64'(bus.rows_out), 64'(4));

        // Twelve cells into a ten-column row.
        base = got_q.size();
        pulse_start();
        send_str("@@@@@@@@@@@@\n", 1'b1);
        wait_done("t6_done");
        chk("t6_nwr", 64'(got_q.size() - base), 64'(3));
        chk_wr("t6_w0", base, 0, 0, 64'b1111);
        chk_wr("t6_w1", base + 1, 0, 4, 64'b1111);
        chk_wr("t6_w2", base + 2, 0, 8, 64'b0011);
        chk("t6_err", 64'(bus.err_out), 64'b001);
        chk("t6_cols", 64'(bus.cols_out), 64'(10));
        chk("t6_rows", 64'(bus.rows_out), 64'(1));

        // Reset while a write is pending, then a clean reload.
        ack_delay = 100;
        pulse_start();
        send_str("@@@@", 1'b0);
        @(negedge clk);
        chk("t7_req", 64'(bus.wr_req_out), 64'(1));
        chk("t7_data", 64'(bus.wr_data_out), 64'b1111);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_req_rst", 64'(bus.wr_req_out), 64'(0));
        chk("t7_ready_rst", 64'(bus.char_ready_out), 64'(0));
        chk("t7_data_rst", 64'(bus.wr_data_out), 64'(0));
        chk("t7_done_rst", 64'(bus.done_out), 64'(0));
        chk("t7_err_rst", 64'(bus.err_out), 64'(0));
        rst = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        chk("t7_idle_ready", 64'(bus.char_ready_out), 64'(0));
        base = got_q.size();
        pulse_start();
        send_str("@.@\n", 1'b1);
        wait_done("t7_done");
        chk("t7_nwr", 64'(got_q.size() - base), 64'(1));
        chk_wr("t7_w0", base, 0, 0, 64'b0101);
        chk("t7_rows", 64'(bus.rows_out), 64'(1));
        chk("t7_cols", 64'(bus.cols_out), 64'(3));
        chk("t7_err", 64'(bus.err_out), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
